// File: rtl/sequenciador_ula.sv
// Operand/writeback sequencer wrapped around the 4-bit add/sub ALU.
// Holds a small register file, accepts one instruction at a time over
// valid/ready, drives the ALU operands from registers and writes the ALU
// result back to the destination register.
//
// state     | meaning
// ----------+------------------------------------------------------------
// OCIOSO    | idle; accepts a direct load or a new instruction
// OPERANDOS | reads rs/rt into a/b and op into selecao
// GRAVA     | ALU inputs stable; result written back at the closing edge
module sequenciador_ula #(
    parameter int LARGURA = 4,
    parameter int N_END   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic               instr_op,
    input  logic [N_END-1:0]   instr_rd,
    input  logic [N_END-1:0]   instr_rs,
    input  logic [N_END-1:0]   instr_rt,
    input  logic               carga_en,
    input  logic [N_END-1:0]   carga_end,
    input  logic [LARGURA-1:0] carga_dado,
    output logic [LARGURA-1:0] a,
    output logic [LARGURA-1:0] b,
    output logic               selecao,
    input  logic [LARGURA-1:0] saida_ula,
    output logic [LARGURA-1:0] resultado,
    output logic               zero,
    output logic               done,
    input  logic [N_END-1:0]   leitura_end,
    output logic [LARGURA-1:0] leitura_dado
);

    localparam int NREG = 2 ** N_END;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        OPERANDOS = 2'd1,
        GRAVA     = 2'd2
    } estado_t;

    estado_t estado, prox;

    logic               op_q;
    logic [N_END-1:0]   rd_q, rs_q, rt_q;
    logic [LARGURA-1:0] regs [NREG];
    logic               aceita;

    // A pending load takes the cycle, so the instruction simply waits.
    assign instr_ready = (estado == OCIOSO) && !carga_en;
    assign aceita      = instr_valid && instr_ready;

    // Register 0 always reads as zero regardless of storage contents.
    assign leitura_dado = (leitura_end == '0) ? '0 : regs[leitura_end];

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox;
    end

    // Next-state logic: fixed three-cycle loop once an instruction is taken.
    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:    if (aceita) prox = OPERANDOS;
            OPERANDOS: prox = GRAVA;
            GRAVA:     prox = OCIOSO;
            default:   prox = OCIOSO;
        endcase
    end

    // Capture instruction fields only at acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q <= 1'b0;
            rd_q <= '0;
            rs_q <= '0;
            rt_q <= '0;
        end else if (aceita) begin
            op_q <= instr_op;
            rd_q <= instr_rd;
            rs_q <= instr_rs;
            rt_q <= instr_rt;
        end
    end

    // Drive ALU operands; they hold their value outside OPERANDOS.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a       <= '0;
            b       <= '0;
            selecao <= 1'b0;
        end else if (estado == OPERANDOS) begin
            a       <= regs[rs_q];
            b       <= regs[rt_q];
            selecao <= op_q;
        end
    end

    // Capture the ALU result and flag completion for one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resultado <= '0;
            zero      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (estado == GRAVA);
            if (estado == GRAVA) begin
                resultado <= saida_ula;
                zero      <= (saida_ula == '0);
            end
        end
    end

    // Register file writes: direct load in OCIOSO, writeback in GRAVA.
    // Writes to register 0 are dropped so it stays zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if ((estado == OCIOSO) && carga_en) begin
            if (carga_end != '0) regs[carga_end] <= carga_dado;
        end else if (estado == GRAVA) begin
            if (rd_q != '0) regs[rd_q] <= saida_ula;
        end
    end

endmodule

// File: tb/tb_sequenciador_ula.sv
// Bench for sequenciador_ula: directed scenarios plus random traffic,
// checked against a register-array model with plain modular arithmetic.
module tb_sequenciador_ula;

    localparam int LARGURA = 4;
    localparam int N_END   = 2;
    localparam int NREG    = 2 ** N_END;
    localparam int MASK    = (1 << LARGURA) - 1;

    logic               clock = 1'b0;
    logic               reset;
    logic               instr_valid;
    logic               instr_ready;
    logic               instr_op;
    logic [N_END-1:0]   instr_rd, instr_rs, instr_rt;
    logic               carga_en;
    logic [N_END-1:0]   carga_end;
    logic [LARGURA-1:0] carga_dado;
    logic [LARGURA-1:0] a, b;
    logic               selecao;
    logic [LARGURA-1:0] saida_ula;
    logic [LARGURA-1:0] resultado;
    logic               zero;
    logic               done;
    logic [N_END-1:0]   leitura_end;
    logic [LARGURA-1:0] leitura_dado;

    int total = 0;
    int bad   = 0;
    int mdl [NREG];

    sequenciador_ula #(.LARGURA(LARGURA), .N_END(N_END)) dut (
        .clock        (clock),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_rs     (instr_rs),
        .instr_rt     (instr_rt),
        .carga_en     (carga_en),
        .carga_end    (carga_end),
        .carga_dado   (carga_dado),
        .a            (a),
        .b            (b),
        .selecao      (selecao),
        .saida_ula    (saida_ula),
        .resultado    (resultado),
        .zero         (zero),
        .done         (done),
        .leitura_end  (leitura_end),
        .leitura_dado (leitura_dado)
    );

    // The adder/subtractor the sequencer sits around.
    assign saida_ula = selecao ? (a - b) : (a + b);

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== exp[31:0]) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int alu_ref(input bit op, input int x, input int y);
        int r;
        r = op ? (x - y) : (x + y);
        return ((r % (MASK + 1)) + (MASK + 1)) % (MASK + 1);
    endfunction

    task automatic check_reg(input int addr);
        int n;
        n = addr;
        leitura_end = n[N_END-1:0];
        #1;
        check("leitura", leitura_dado, (addr == 0) ? 0 : mdl[addr]);
    endtask

    task automatic do_load(input int addr, input int data);
        carga_en   = 1'b1;
        carga_end  = addr[N_END-1:0];
        carga_dado = data[LARGURA-1:0];
        #1;
        check("ready_load", instr_ready, 0);
        @(posedge clock); #1;
        carga_en = 1'b0;
        if (addr != 0) mdl[addr] = data & MASK;
        check_reg(addr);
    endtask

    // Issue one instruction and follow it to its done pulse.
    // With carga_mid a load is attempted during OPERANDOS; it must be ignored.
    task automatic do_instr(input bit op, input int rd, input int rs, input int rt,
                            input bit carga_mid);
        int va, vb, r;
        va = mdl[rs];
        vb = mdl[rt];
        r  = alu_ref(op, va, vb);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd[N_END-1:0];
        instr_rs    = rs[N_END-1:0];
        instr_rt    = rt[N_END-1:0];
        #1;
        check("ready_idle", instr_ready, 1);
        @(posedge clock); #1;
        instr_valid = 1'b0;
        instr_op    = 1'($urandom);
        instr_rd    = N_END'($urandom);
        instr_rs    = N_END'($urandom);
        instr_rt    = N_END'($urandom);
        if (carga_mid) begin
            carga_en   = 1'b1;
            carga_end  = rs[N_END-1:0];
            carga_dado = LARGURA'(~va);
        end
        check("ready_busy", instr_ready, 0);
        @(posedge clock); #1;
        carga_en = 1'b0;
        check("a", a, va);
        check("b", b, vb);
        check("selecao", selecao, op);
        check("done_grava", done, 0);
        @(posedge clock); #1;
        if (rd != 0) mdl[rd] = r;
        check("resultado", resultado, r);
        check("zero", zero, (r == 0) ? 1 : 0);
        check("done_pulse", done, 1);
        check_reg(rd);
        @(posedge clock); #1;
        check("done_low", done, 0);
    endtask

    initial begin
        int va, vb, r;
        int q_op [4];
        int q_rd [4];
        int q_rs [4];
        int q_rt [4];

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr_op    = 1'b0;
        instr_rd    = '0;
        instr_rs    = '0;
        instr_rt    = '0;
        carga_en    = 1'b0;
        carga_end   = '0;
        carga_dado  = '0;
        leitura_end = '0;
        for (int i = 0; i < NREG; i++) mdl[i] = 0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_sel", selecao, 0);
        check("rst_res", resultado, 0);
        check("rst_zero", zero, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        #1;
        check("rst_ready", instr_ready, 1);

        // 1: add with wrap-around
        do_load(1, 7);
        do_load(2, 12);
        do_instr(1'b0, 3, 1, 2, 1'b0);

        // 2: subtract with borrow, then self-subtract to zero
        do_load(1, 3);
        do_load(2, 5);
        do_instr(1'b1, 1, 1, 2, 1'b0);
        do_instr(1'b1, 2, 1, 1, 1'b0);

        // 3: register 0 discards writeback and load
        do_load(1, 4);
        do_load(2, 4);
        do_instr(1'b0, 0, 1, 2, 1'b0);
        check_reg(0);
        do_load(0, 9);

        // 4: four instructions with instr_valid held high throughout
        for (int k = 0; k < 4; k++) begin
            q_op[k] = $urandom_range(0, 1);
            q_rd[k] = $urandom_range(0, NREG - 1);
            q_rs[k] = $urandom_range(0, NREG - 1);
            q_rt[k] = $urandom_range(0, NREG - 1);
        end
        instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr_op = q_op[k][0];
            instr_rd = q_rd[k][N_END-1:0];
            instr_rs = q_rs[k][N_END-1:0];
            instr_rt = q_rt[k][N_END-1:0];
            va = mdl[q_rs[k]];
            vb = mdl[q_rt[k]];
            r  = alu_ref(q_op[k][0], va, vb);
            #1;
            check("b2b_ready_idle", instr_ready, 1);
            @(posedge clock); #1;
            if (k < 3) begin
                instr_op = q_op[k+1][0];
                instr_rd = q_rd[k+1][N_END-1:0];
                instr_rs = q_rs[k+1][N_END-1:0];
                instr_rt = q_rt[k+1][N_END-1:0];
            end else begin
                instr_valid = 1'b0;
            end
            check("b2b_ready_op", instr_ready, 0);
            @(posedge clock); #1;
            check("b2b_ready_gr", instr_ready, 0);
            check("b2b_a", a, va);
            check("b2b_b", b, vb);
            check("b2b_done_low", done, 0);
            @(posedge clock);
            if (q_rd[k] != 0) mdl[q_rd[k]] = r;
            #1;
            check("b2b_done", done, 1);
            check("b2b_res", resultado, r);
        end
        @(posedge clock); #1;
        check("b2b_done_end", done, 0);
        for (int i = 0; i < NREG; i++) check_reg(i);

        // 5: load and instruction together; load wins, instruction follows
        do_load(2, 1);
        instr_valid = 1'b1;
        instr_op    = 1'b0;
        instr_rd    = 2'd3;
        instr_rs    = 2'd1;
        instr_rt    = 2'd2;
        carga_en    = 1'b1;
        carga_end   = 2'd1;
        carga_dado  = 4'd6;
        #1;
        check("tie_ready", instr_ready, 0);
        @(posedge clock); #1;
        carga_en = 1'b0;
        mdl[1] = 6;
        do_instr(1'b0, 3, 1, 2, 1'b1);
        check_reg(1);

        // 6: reset while in GRAVA aborts the writeback
        do_load(1, 5);
        do_load(2, 2);
        instr_valid = 1'b1;
        instr_op    = 1'b0;
        instr_rd    = 2'd3;
        instr_rs    = 2'd1;
        instr_rt    = 2'd2;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        @(posedge clock); #1;
        check("pre_rst_a", a, 5);
        reset = 1'b1;
        #1;
        for (int i = 0; i < NREG; i++) mdl[i] = 0;
        check("arst_a", a, 0);
        check("arst_b", b, 0);
        check("arst_res", resultado, 0);
        check("arst_done", done, 0);
        check("arst_zero", zero, 0);
        #1;
        reset = 1'b0;
        #1;
        check("arst_ready", instr_ready, 1);
        @(posedge clock); #1;
        check("arst_done2", done, 0);
        check_reg(3);

        // random traffic
        for (int i = 0; i < 20; i++) do_load($urandom_range(0, NREG - 1), $urandom_range(0, MASK));
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0)
                do_load($urandom_range(0, NREG - 1), $urandom_range(0, MASK));
            else
                do_instr(1'($urandom), $urandom_range(0, NREG - 1),
                         $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
                         1'($urandom));
        end
        for (int i = 0; i < NREG; i++) check_reg(i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequenciador_ula.md
Name: sequenciador_ula

Overview:
- Operand/writeback sequencer directly upstream and downstream of the 4-bit add/sub ALU.
- Holds a small register file and accepts one instruction at a time over a valid/ready handshake.
- Drives the ALU inputs a, b and selecao from registers, then writes the ALU result (saida_ula) back to the destination register.
- Gives the MIPS datapath its first stateful execute loop around the combinational adder/subtractor.

Parameters:
LARGURA, 4, data width; must equal the ALU operand width
N_END, 2, register address width (2**N_END registers, default 4)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction present
instr_ready  output  1  block can accept an instruction this cycle
instr_op  input  1  0 = add, 1 = subtract (copied to selecao)
instr_rd  input  N_END  destination register
instr_rs  input  N_END  first operand register (drives a)
instr_rt  input  N_END  second operand register (drives b)
carga_en  input  1  direct register load strobe
carga_end  input  N_END  load address
carga_dado  input  LARGURA  load data
a  output  LARGURA  ALU operand a (registered)
b  output  LARGURA  ALU operand b (registered)
selecao  output  1  ALU op select (registered)
saida_ula  input  LARGURA  ALU result (combinational from a, b, selecao)
resultado  output  LARGURA  last written-back result (registered)
zero  output  1  resultado == 0 (registered with resultado)
done  output  1  one-cycle pulse after writeback
leitura_end  input  N_END  debug read address
leitura_dado  output  LARGURA  combinational read of register leitura_end

Behaviour:
- Reset (async, active-high) forces:
  - all registers, a, b, resultado: 0
  - selecao, done, zero: 0
  - state: OCIOSO
  - reset mid-instruction aborts it with no writeback.
- Register 0 is hardwired to zero:
  - reads return 0
  - writes (load or writeback) are discarded.
- instr_ready = (state == OCIOSO) && !carga_en; combinational.
- Direct load: if carga_en in OCIOSO, R[carga_end] <= carga_dado at the edge. carga_en outside OCIOSO is ignored.
- Load has priority over an instruction in the same cycle: instr_ready is low, so the instruction is not accepted and stays pending.
- FSM states OCIOSO, OPERANDOS, GRAVA:
  - OCIOSO: instr_valid && instr_ready at an edge latches op/rd/rs/rt, then -> OPERANDOS.
  - OPERANDOS: at the edge, a <= R[rs], b <= R[rt], selecao <= op, then -> GRAVA.
  - GRAVA: a, b, selecao are stable for the whole cycle. At the edge:
    - R[rd] <= saida_ula (unless rd == 0)
    - resultado <= saida_ula; zero <= (saida_ula == 0)
    - done <= 1
    - -> OCIOSO
- done is high for exactly the first OCIOSO cycle after GRAVA, and low otherwise.
- Latency: acceptance edge E, writeback edge E+2, done visible in the cycle after E+2.
- A back-to-back instruction can be accepted at E+3, giving one instruction per 3 cycles.
- a, b and selecao hold their last values outside OPERANDOS updates.
- Arithmetic is performed by the ALU modulo 2**LARGURA. The block performs no arithmetic and detects no carry/overflow.
- rs == rd or rt == rd: operands are read in OPERANDOS, before writeback, so there is no hazard. The next instruction sees the written value.
- leitura_dado reflects a writeback or load from the edge onward.
- instr_* fields are sampled only at acceptance. Changes afterwards have no effect.

Test Plan:
1. Load R1=7, R2=12; issue add rd=3 rs=1 rt=2 -> a=7, b=12, selecao=0 in GRAVA; R3=3 (wrap); resultado=3, zero=0, done pulses once at E+3.
2. R1=3, R2=5; issue sub rd=1 rs=1 rt=2 -> R1=14, resultado=14. Next: sub rd=2 rs=1 rt=1 -> R2=0, zero=1.
3. Issue add rd=0 rs=1 rt=2 with R1=4, R2=4 -> resultado=8, leitura_end=0 reads 0. A direct load of 9 to address 0 also reads back 0.
4. Hold instr_valid high with 4 queued instructions -> instr_ready high only in OCIOSO, one acceptance every 3 cycles, 4 done pulses, and final register values correct.
5. carga_en and instr_valid together in OCIOSO -> load takes effect, instr_ready=0 that cycle, instruction accepted the next cycle using the newly loaded value. carga_en during OPERANDOS is ignored.
6. Assert reset in GRAVA -> no writeback to rd, all outputs 0 immediately (async), FSM in OCIOSO, instr_ready=1 after release.
